// File: rtl/mm_pkg.sv
// mm_pkg: shared constants and FSM state encoding for the Montgomery exponentiation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mm_pkg;

   // Operand width and field modulus q = 2^255 - 19, with Montgomery radix R = 2^255.
   localparam int DATA_W = 255;
   localparam logic [DATA_W-1:0] Q =
      255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
   // R mod q, i.e. the value 1 expressed in Montgomery form.
   localparam logic [DATA_W-1:0] R_MOD_Q = 255'd19;

   // Sequencer states.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SQR_ISSUE = 3'd1;
   localparam logic [2:0] ST_SQR_WAIT  = 3'd2;
   localparam logic [2:0] ST_MUL_ISSUE = 3'd3;
   localparam logic [2:0] ST_MUL_WAIT  = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/mm_exp_seq.sv
// mm_exp_seq: base^exp in the Montgomery domain, left-to-right square-and-multiply on one external MM unit.
// Latency: EXP_W squarings + popcount(exp) multiplies, each 1 issue cycle + MM latency, plus start and DONE cycles.
// Backpressure: none; one MM op outstanding, waits indefinitely for i_mm_valid; i_start ignored while busy.
module mm_exp_seq #(
   parameter int DATA_W = 255,
   parameter int EXP_W  = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_base,
   input  logic [EXP_W-1:0]  i_exp,
   input  logic [DATA_W-1:0] i_one_mont,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_result,
   output logic              o_mm_valid,
   output logic [DATA_W-1:0] o_mm_x,
   output logic [DATA_W-1:0] o_mm_y,
   input  logic              i_mm_valid,
   input  logic [DATA_W-1:0] i_mm_result
);
   import mm_pkg::*;

   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   logic [2:0]        r_state;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_base;
   logic [EXP_W-1:0]  r_exp;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_result;

   logic w_bit;
   logic w_idx_zero;
   logic w_mul_phase;

   // Current exponent bit and end-of-exponent detection; the index never decrements past zero.
   assign w_bit       = r_exp[r_idx];
   assign w_idx_zero  = (r_idx == '0);
   assign w_mul_phase = (r_state == ST_MUL_ISSUE) || (r_state == ST_MUL_WAIT);

   // Operands come straight from state registers, which only change on a response,
   // so they stay stable from issue until the MM unit answers.
   assign o_busy     = (r_state != ST_IDLE);
   assign o_done     = (r_state == ST_DONE);
   assign o_result   = r_result;
   assign o_mm_valid = (r_state == ST_SQR_ISSUE) || (r_state == ST_MUL_ISSUE);
   assign o_mm_x     = r_acc;
   assign o_mm_y     = w_mul_phase ? r_base : r_acc;

   // Square-and-multiply sequencer; the final product is latched into r_result on the way
   // into DONE so the result is already valid during the done pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_base   <= '0;
         r_exp    <= '0;
         r_idx    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_acc   <= i_one_mont;
                  r_base  <= i_base;
                  r_exp   <= i_exp;
                  r_idx   <= IDX_W'(EXP_W - 1);
                  r_state <= ST_SQR_ISSUE;
               end
            end
            ST_SQR_ISSUE: begin
               r_state <= ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
               if (i_mm_valid) begin
                  r_acc <= i_mm_result;
                  if (w_bit) begin
                     r_state <= ST_MUL_ISSUE;
                  end else if (!w_idx_zero) begin
                     r_idx   <= r_idx - IDX_W'(1);
                     r_state <= ST_SQR_ISSUE;
                  end else begin
                     r_result <= i_mm_result;
                     r_state  <= ST_DONE;
                  end
               end
            end
            ST_MUL_ISSUE: begin
               r_state <= ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
               if (i_mm_valid) begin
                  r_acc <= i_mm_result;
                  if (!w_idx_zero) begin
                     r_idx   <= r_idx - IDX_W'(1);
                     r_state <= ST_SQR_ISSUE;
                  end else begin
                     r_result <= i_mm_result;
                     r_state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mm_exp_seq.md
MM_EXP_SEQ -- requirements
Module: mm_exp_seq

Interface
REQ-001 Parameter DATA_W, default 255, sets the operand and result width in bits.
REQ-002 Parameter EXP_W, default 255, sets the exponent width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports i_clk and i_rst_n.
REQ-004 Ports, listed as name, direction, width, meaning:
- i_clk, in, 1, clock; all state updates on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_start, in, 1, start request; sampled only in IDLE.
- i_base, in, DATA_W, base operand in Montgomery form; captured on start.
- i_exp, in, EXP_W, exponent; captured on start.
- i_one_mont, in, DATA_W, value R mod q (= 19) in Montgomery form; captured on start.
- o_busy, out, 1, high from the start-accept cycle through the DONE cycle.
- o_done, out, 1, one-cycle pulse; o_result is valid on this cycle.
- o_result, out, DATA_W, final accumulator; held until the next accepted start.
- o_mm_valid, out, 1, one-cycle issue pulse to the external MM datapath.
- o_mm_x, out, DATA_W, first MM operand; stable from issue until response.
- o_mm_y, out, DATA_W, second MM operand; stable from issue until response.
- i_mm_valid, in, 1, MM response strobe; any latency of 1 cycle or more.
- i_mm_result, in, DATA_W, MM product x*y*R^-1 mod q; valid with i_mm_valid.

Function
REQ-005 The block SHALL compute i_base^i_exp in the Montgomery domain by left-to-right square-and-multiply on one shared MM resource.
REQ-006 States SHALL be IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
REQ-007 IDLE to SQR_ISSUE on i_start: accumulator <= i_one_mont; capture base and exp; bit index <= EXP_W-1.
REQ-008 SQR_ISSUE: pulse o_mm_valid with x = y = accumulator; go to SQR_WAIT.
REQ-009 SQR_WAIT on i_mm_valid: accumulator <= i_mm_result. Then go to MUL_ISSUE if exp[idx]=1; else to SQR_ISSUE if idx>0; else to DONE.
REQ-010 MUL_ISSUE: pulse o_mm_valid with x = accumulator, y = base; go to MUL_WAIT.
REQ-011 MUL_WAIT on i_mm_valid: accumulator <= i_mm_result. Then, if idx>0, decrement idx and go to SQR_ISSUE; else go to DONE.
REQ-012 SQR_WAIT with exp[idx]=0 and idx>0 SHALL decrement idx on leaving.
REQ-013 Leading zero bits SHALL NOT be skipped: exactly EXP_W squarings plus popcount(exp) multiplies.
REQ-014 DONE: o_done=1 and o_result <= accumulator for one cycle; then return to IDLE.
REQ-015 i_start while busy SHALL be ignored; captured operands SHALL NOT change.
REQ-016 i_mm_valid outside a WAIT state SHALL be ignored.
REQ-017 At most one MM operation SHALL be outstanding at any time.
REQ-018 Back-to-back starts: i_start in the cycle after DONE SHALL be accepted.
REQ-019 The bit index SHALL be ceil(log2(EXP_W)) bits wide and SHALL never wrap below 0.

Reset
REQ-020 On i_rst_n low: state IDLE; o_busy, o_done, o_mm_valid = 0; o_result, o_mm_x, o_mm_y, accumulator, index = 0.
REQ-021 Reset mid-operation SHALL abort immediately; a late i_mm_valid after reset release is ignored per REQ-016.

Structure
REQ-022 Package mm_pkg SHALL hold DATA_W, Q = 2^255-19, R_MOD_Q = 19 and the state enumeration.
REQ-023 No sub-module: the MM datapath is external, reached only through the o_mm_*/i_mm_* port, so it can be shared or pipelined.

Verification
REQ-024 The bench SHALL use a behavioural MM model with programmable latency (1, 3 and random 1-8 cycles).
REQ-025 Scenarios:
- exp=0, any base, one_mont=19 -> o_result=19; 255 MM ops, all squares.
- exp=1, base=B -> o_result=B; 255 squares and 1 multiply.
- exp=3, base=B -> o_result = B^3 (Montgomery, golden model); 257 ops; multiply only after the last two squares.
- exp all ones -> 510 ops alternating S,M; o_result matches golden model; one o_done pulse.
- i_start pulsed while busy, and i_mm_valid injected in SQR_ISSUE -> no state or operand change; result unaffected.
- i_rst_n low during MUL_WAIT -> all outputs 0 next edge; a new start with exp=1 then yields o_result=base.
